// File: rtl/cla_pkg.sv
// ============================================================================
//  Module      : cla_pkg
//  Description : Shared types and elaboration helpers for the pipelined
//                carry-lookahead adder: stage count, parameter legality,
//                lookahead tree depth and the (generate, propagate) pair.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cla_pkg;

    // Group generate/propagate pair carried through the lookahead tree.
    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Pipeline depth: one lookahead slice resolved per stage.
    function automatic int cla_stages(input int width, input int block);
        return width / block;
    endfunction

    // WIDTH must be a multiple of BLOCK; BLOCK a power of two in 4..WIDTH.
    function automatic bit cla_params_ok(input int width, input int block);
        return (block >= 4) && (block <= width) &&
               ((block & (block - 1)) == 0) && ((width % block) == 0);
    endfunction

    // Number of radix-4 prefix levels needed to span a BLOCK-bit slice.
    function automatic int cla_levels(input int block);
        int n;
        int span;
        n    = 0;
        span = 1;
        while (span < block) begin
            span = span * 4;
            n    = n + 1;
        end
        return n;
    endfunction

    // Prefix operator: hi covers the more significant bits.
    function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
        gp_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cla_block_slice.sv
// ============================================================================
//  Module      : cla_block_slice
//  Description : Purely combinational BLOCK-bit carry-lookahead slice built
//                from a radix-4 parallel-prefix tree.
//  Revision    : 1.0 - initial release
//
//  Ports:
//    a, b  in  BLOCK  slice operands
//    cin   in  1      carry into bit 0 of the slice
//    sum   out BLOCK  slice sum
//    g     out 1      group generate of the whole slice
//    p     out 1      group propagate of the whole slice
// ============================================================================
`default_nettype none

module cla_block_slice
    import cla_pkg::*;
#(
    parameter int BLOCK = 16
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] sum,
    output logic             g,
    output logic             p
);

    localparam int LEVELS = cla_levels(BLOCK);

    // Row l holds, per bit i, the group G/P of bits [i : i-4^l+1] (clipped at 0).
    // The top row therefore holds the prefix G/P of bits [i : 0].
    logic [LEVELS:0][BLOCK-1:0] w_gl;
    logic [LEVELS:0][BLOCK-1:0] w_pl;
    logic [BLOCK-1:0]           w_c;
    gp_t                        w_acc;

    always_comb begin
        w_gl  = '0;
        w_pl  = '0;
        w_c   = '0;
        w_acc = '0;
        sum   = '0;
        g     = 1'b0;
        p     = 1'b0;

        w_gl[0] = a & b;
        w_pl[0] = a ^ b;

        // Each level folds up to four neighbouring groups spaced 4^l apart.
        for (int l = 0; l < LEVELS; l++) begin
            for (int i = 0; i < BLOCK; i++) begin
                w_acc = '{g: w_gl[l][i], p: w_pl[l][i]};
                for (int j = 1; j < 4; j++) begin
                    if (i - j * (1 << (2 * l)) >= 0) begin
                        w_acc = gp_combine(w_acc,
                                           '{g: w_gl[l][i - j * (1 << (2 * l))],
                                             p: w_pl[l][i - j * (1 << (2 * l))]});
                    end
                end
                w_gl[l+1][i] = w_acc.g;
                w_pl[l+1][i] = w_acc.p;
            end
        end

        // Carry into bit i is the prefix of bits below it applied to cin.
        w_c[0] = cin;
        for (int i = 1; i < BLOCK; i++) begin
            w_c[i] = w_gl[LEVELS][i-1] | (w_pl[LEVELS][i-1] & cin);
        end

        sum = w_pl[0] ^ w_c;
        g   = w_gl[LEVELS][BLOCK-1];
        p   = w_pl[LEVELS][BLOCK-1];
    end

endmodule

`default_nettype wire

// File: rtl/pipelined_cla_adder.sv
// ============================================================================
//  Module      : pipelined_cla_adder
//  Description : Pipelined carry-lookahead adder/subtractor. One BLOCK-bit
//                lookahead slice is resolved per clock; the inter-slice carry
//                is registered. The whole pipe advances together under a
//                valid/ready handshake on both sides.
//  Revision    : 1.0 - initial release
//
//  Optional feature macro: PIPELINED_CLA_OVERFLOW_EN adds the signed
//  overflow output, aligned with s.
//
//  Ports:
//    clk        in  1      rising-edge clock
//    rst        in  1      synchronous active-high reset
//    in_valid   in  1      operands valid
//    in_ready   out 1      operands accepted this cycle
//    x, y       in  WIDTH  operands
//    carry_in   in  1      carry into bit 0 (ignored when sub=1)
//    sub        in  1      1: x - y
//    out_valid  out 1      result valid
//    out_ready  in  1      downstream accepts result
//    s          out WIDTH  sum/difference (mod 2^WIDTH)
//    carry_out  out 1      carry out of MSB (sub: 1 = no borrow)
//    overflow   out 1      signed overflow (macro build only)
// ============================================================================
`default_nettype none

module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int BLOCK = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             carry_out
`ifdef PIPELINED_CLA_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int STAGES = cla_stages(WIDTH, BLOCK);

    if (!cla_params_ok(WIDTH, BLOCK)) begin : g_bad_params
        $error("pipelined_cla_adder: WIDTH must be a multiple of BLOCK, BLOCK a power of two in 4..WIDTH");
    end

    // Stage k registers: r_x holds finished sum slices 0..k plus untouched
    // upper x slices; r_y holds the (possibly inverted) y operand; r_c is the
    // carry out of slice k.
    logic [STAGES-1:0] r_valid;
    logic [WIDTH-1:0]  r_x [STAGES];
    logic [WIDTH-1:0]  r_y [STAGES];
    logic [STAGES-1:0] r_c;

    logic [WIDTH-1:0]  w_nx [STAGES];
    logic [WIDTH-1:0]  w_ny [STAGES];
    logic [STAGES-1:0] w_nc;
    logic [STAGES-1:0] w_nv;
    logic              w_adv;

`ifdef PIPELINED_CLA_OVERFLOW_EN
    logic              r_ovf;
    logic              w_ovf;
`endif

    // Single global advance: bubbles are not squeezed out.
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    // Valid bits simply shift; the oldest bit falls off the top.
    assign w_nv = (r_valid << 1) | STAGES'(in_valid);

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] w_a;
        logic [WIDTH-1:0] w_b;
        logic             w_ci;
        logic [BLOCK-1:0] w_sum;
        logic             w_g;
        logic             w_p;
        logic [WIDTH-1:0] w_x_next;

        if (k == 0) begin : g_first
            // Subtraction is x + ~y + 1; carry_in is ignored then.
            assign w_a  = x;
            assign w_b  = sub ? ~y : y;
            assign w_ci = sub | carry_in;
        end else begin : g_next
            assign w_a  = r_x[k-1];
            assign w_b  = r_y[k-1];
            assign w_ci = r_c[k-1];
        end

        cla_block_slice #(
            .BLOCK (BLOCK)
        ) u_slice (
            .a   (w_a[k*BLOCK +: BLOCK]),
            .b   (w_b[k*BLOCK +: BLOCK]),
            .cin (w_ci),
            .sum (w_sum),
            .g   (w_g),
            .p   (w_p)
        );

        always_comb begin
            w_x_next                   = w_a;
            w_x_next[k*BLOCK +: BLOCK] = w_sum;
        end

        assign w_nx[k] = w_x_next;
        assign w_ny[k] = w_b;
        assign w_nc[k] = w_g | (w_p & w_ci);

`ifdef PIPELINED_CLA_OVERFLOW_EN
        if (k == STAGES - 1) begin : g_last
            // Carry into the MSB is recovered from its sum bit and operands.
            assign w_ovf = (w_sum[BLOCK-1] ^ w_a[WIDTH-1] ^ w_b[WIDTH-1]) ^ w_nc[k];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_c     <= '0;
            for (int i = 0; i < STAGES; i++) begin
                r_x[i] <= '0;
                r_y[i] <= '0;
            end
`ifdef PIPELINED_CLA_OVERFLOW_EN
            r_ovf   <= 1'b0;
`endif
        end else if (w_adv) begin
            r_valid <= w_nv;
            r_c     <= w_nc;
            for (int i = 0; i < STAGES; i++) begin
                r_x[i] <= w_nx[i];
                r_y[i] <= w_ny[i];
            end
`ifdef PIPELINED_CLA_OVERFLOW_EN
            r_ovf   <= w_ovf;
`endif
        end
    end

    assign out_valid = r_valid[STAGES-1];
    assign s         = r_x[STAGES-1];
    assign carry_out = r_c[STAGES-1];
`ifdef PIPELINED_CLA_OVERFLOW_EN
    assign overflow  = r_ovf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipelined_cla_adder.sv
// ============================================================================
//  Module      : tb_pipelined_cla_adder
//  Description : Directed self-checking bench for pipelined_cla_adder
//                (WIDTH=32, BLOCK=16). Define PIPELINED_CLA_OVERFLOW_EN to
//                also check the overflow output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipelined_cla_adder;

    localparam int WIDTH  = 32;
    localparam int BLOCK  = 16;
    localparam int STAGES = WIDTH / BLOCK;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] x = '0;
    logic [WIDTH-1:0] y = '0;
    logic             carry_in = 1'b0;
    logic             sub = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] s;
    logic             carry_out;
`ifdef PIPELINED_CLA_OVERFLOW_EN
    logic             overflow;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    pipelined_cla_adder #(
        .WIDTH (WIDTH),
        .BLOCK (BLOCK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .carry_in  (carry_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .carry_out (carry_out)
`ifdef PIPELINED_CLA_OVERFLOW_EN
        ,
        .overflow  (overflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One isolated transaction; measures latency and checks the result.
    task automatic run_one(input string tag, input logic [31:0] xa, input logic [31:0] yb,
                           input logic ci, input logic sb, input logic [31:0] exp_s,
                           input logic exp_c, input logic exp_ovf);
        int lat;
        in_valid  = 1'b1;
        x         = xa;
        y         = yb;
        carry_in  = ci;
        sub       = sb;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(STAGES));
        check({tag, "_s"}, 64'(s), 64'(exp_s));
        check({tag, "_cout"}, 64'(carry_out), 64'(exp_c));
`ifdef PIPELINED_CLA_OVERFLOW_EN
        check({tag, "_ovf"}, 64'(overflow), 64'(exp_ovf));
`else
        if (exp_ovf === 1'bx) $display("unexpected x in overflow expectation for %s", tag);
`endif
    endtask

    logic [31:0] sx [8];
    logic [31:0] sy [8];
    logic [32:0] sexp [8];
    logic [32:0] expq [$];

    initial begin
        // ---------------- reset ----------------
        rst = 1'b1;
        step();
        step();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_s", 64'(s), 64'd0);
        check("rst_cout", 64'(carry_out), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef PIPELINED_CLA_OVERFLOW_EN
        check("rst_ovf", 64'(overflow), 64'd0);
`endif
        rst = 1'b0;
        step();

        // ---------------- directed single items ----------------
        run_one("add_cross",  32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0);
        run_one("sub_borrow", 32'd5,         32'd7,         1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_one("sub_pos",    32'd7,         32'd5,         1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
        run_one("add_wrap",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        run_one("add_cin",    32'd1,         32'd1,         1'b1, 1'b0, 32'h0000_0003, 1'b0, 1'b0);
        run_one("sub_igncin", 32'd10,        32'd3,         1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0);
        run_one("sub_zero",   32'd0,         32'd1,         1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_one("add_ovf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        run_one("sub_ovf",    32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

        // ---------------- back-to-back stream ----------------
        for (int i = 0; i < 8; i++) begin
            sx[i]   = 32'h1111_1111 * i + 32'h0000_FFFF;
            sy[i]   = 32'h2000_0000 * i + 32'h0000_0001;
            sexp[i] = {1'b0, sx[i]} + {1'b0, sy[i]};
        end
        out_ready = 1'b1;
        sub       = 1'b0;
        carry_in  = 1'b0;
        for (int cyc = 0; cyc < 8 + STAGES; cyc++) begin
            int idx;
            if (cyc < 8) begin
                in_valid = 1'b1;
                x        = sx[cyc];
                y        = sy[cyc];
            end else begin
                in_valid = 1'b0;
            end
            step();
            idx = cyc + 1 - STAGES;
            if (idx < 0) begin
                check("stream_lead_valid", 64'(out_valid), 64'd0);
            end else if (idx < 8) begin
                check($sformatf("stream%0d_valid", idx), 64'(out_valid), 64'd1);
                check($sformatf("stream%0d_s", idx), 64'({carry_out, s}), 64'(sexp[idx]));
            end
        end

        // ---------------- backpressure ----------------
        begin
            int sent;
            int got;
            logic pv, pr, pir;
            logic [32:0] pres;
            sent = 0;
            got  = 0;
            for (int c = 0; c < 40 && got < 6; c++) begin
                out_ready = !(c >= 4 && c < 7);
                if (sent < 6) begin
                    in_valid = 1'b1;
                    x        = 32'hFFFF_0000 + sent;
                    y        = 32'h0001_0000 * (sent + 1) + 32'h0000_8000;
                end else begin
                    in_valid = 1'b0;
                end
                #1;
                pv   = out_valid;
                pr   = out_ready;
                pir  = in_ready;
                pres = {carry_out, s};
                if (pv && !pr) begin
                    check("bp_in_ready_low", 64'(pir), 64'd0);
                    if (expq.size() > 0) check("bp_stall_s", 64'(pres), 64'(expq[0]));
                end
                @(posedge clk);
                if (in_valid && pir) begin
                    expq.push_back({1'b0, x} + {1'b0, y});
                    sent++;
                end
                if (pv && pr) begin
                    if (expq.size() > 0) begin
                        check($sformatf("bp_item%0d", got), 64'(pres), 64'(expq.pop_front()));
                    end else begin
                        check("bp_unexpected_item", 64'd1, 64'd0);
                    end
                    got++;
                end
                #1;
            end
            in_valid = 1'b0;
            check("bp_delivered", 64'(got), 64'd6);
            check("bp_queue_empty", 64'(expq.size()), 64'd0);
        end

        // ---------------- reset mid-flight ----------------
        begin
            logic seen;
            out_ready = 1'b0;
            step();
            in_valid = 1'b1;
            x = 32'h1234_0000;
            y = 32'h0000_5678;
            step();
            x = 32'hAAAA_0000;
            y = 32'h0000_5555;
            step();
            in_valid = 1'b0;
            rst = 1'b1;
            step();
            check("mrst_out_valid", 64'(out_valid), 64'd0);
            check("mrst_s", 64'(s), 64'd0);
            check("mrst_cout", 64'(carry_out), 64'd0);
            rst       = 1'b0;
            out_ready = 1'b1;
            seen      = 1'b0;
            for (int c = 0; c < 6; c++) begin
                step();
                seen = seen | out_valid;
            end
            check("mrst_no_ghost", 64'(seen), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor.
- Splits a WIDTH-bit operation into STAGES = WIDTH/BLOCK slices and resolves one BLOCK-bit lookahead slice per clock.
- The inter-slice carry is registered between stages; operands are skewed on entry and results deskewed on exit.
- Sits in the datapath wherever a wide add would limit fmax; valid/ready on both sides, so it drops into streaming pipelines.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of BLOCK.
- BLOCK, 16, bits resolved per pipeline stage; must be a power of two, 4..WIDTH.
- STAGES, WIDTH/BLOCK (derived localparam, not overridable), pipeline depth.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operands valid
- in_ready  out  1  block accepts operands this cycle
- x  in  WIDTH  operand A
- y  in  WIDTH  operand B
- carry_in  in  1  carry into bit 0 (ignored when sub=1)
- sub  in  1  1: compute x - y (x + ~y + 1)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- s  out  WIDTH  sum/difference
- carry_out  out  1  carry out of MSB; for sub, 1 means no borrow

Behaviour:
- Reset:
  - All stage valid bits clear, so out_valid=0.
  - s=0, carry_out=0, in_ready=1 in the cycle after reset.
  - Reset mid-operation discards every in-flight item; no partial result appears.
- Advance:
  - adv = !out_valid || out_ready.
  - in_ready = adv, purely combinational from out_valid and out_ready.
  - On adv, every stage shifts by one, including bubbles. Bubbles are not compressed; the whole pipe stalls together.
- Transfer: an item is accepted when in_valid && in_ready, and delivered when out_valid && out_ready.
- Latency: exactly STAGES cycles from acceptance to out_valid when out_ready is held high. Throughput is one item per cycle.
- Stage k (0..STAGES-1):
  - Adds slice k of x and y' (y' = sub ? ~y : y) with the carry registered from stage k-1. Stage 0 uses sub ? 1 : carry_in.
  - The slice sum is produced by one BLOCK-bit lookahead slice (group G/P, carry = G | P&cin).
  - Slices above k ride along unmodified; completed lower slices ride along to the output.
- Stall: while adv=0, all registers hold. s and carry_out stay stable while out_valid=1 and out_ready=0.
- Width rules:
  - s is the result modulo 2^WIDTH; there is no saturation.
  - carry_out is the carry out of bit WIDTH-1 of x + y' + cin.
- STAGES=1: the block degenerates to a single registered adder with latency 1; the handshake rules are unchanged.
- Simultaneous accept and deliver on a full pipe in the same cycle is legal and loses nothing.
- Outputs are registered: s, carry_out and out_valid come straight from flops.

Optional Feature:
- Macro: PIPELINED_CLA_OVERFLOW_EN.
- Defined:
  - Adds output port overflow (1 bit), aligned with s.
  - overflow = signed two's-complement overflow = carry into MSB XOR carry out of MSB, computed in the last stage.
  - overflow resets to 0 and holds under stall like s.
- Undefined: the port and its logic are absent.

Decomposition:
- Package cla_pkg holds:
  - Function cla_stages(WIDTH, BLOCK) returning the stage count.
  - Elaboration-time checks for the WIDTH/BLOCK constraints.
  - A gp_t pair type {g, p} used by the lookahead slice.
- Sub-module cla_block_slice, parametrised by BLOCK:
  - Purely combinational BLOCK-bit lookahead slice (inputs a, b, cin; outputs sum, G, P).
  - Built from a radix-4 lookahead tree.
  - Instantiated once per stage via generate.

Test Plan (WIDTH=32, BLOCK=16, STAGES=2 unless noted):
- Add: x=0x0000FFFF, y=0x00000001, carry_in=0, sub=0, out_ready=1 → after 2 cycles s=0x00010000, carry_out=0; this exercises carry across the stage boundary.
- Subtract: x=5, y=7, sub=1 → s=0xFFFFFFFE, carry_out=0 (borrow). x=7, y=5 → s=2, carry_out=1.
- Back-to-back stream: 8 consecutive items with out_ready=1 → 8 results on 8 consecutive cycles, in order, starting 2 cycles after the first accept.
- Backpressure: fill the pipe, drop out_ready for 3 cycles → in_ready=0 and s stable; release → no loss or duplication, order preserved.
- Reset mid-flight: assert rst with 2 items in flight → next cycle out_valid=0, s=0, and neither item ever appears.
- Macro build with PIPELINED_CLA_OVERFLOW_EN: x=0x7FFFFFFF, y=1 → overflow=1, s=0x80000000, carry_out=0. Rerun the first scenario with WIDTH=64, BLOCK=8 → latency 8, same sums.
